// File: rtl/ov7670_power_seq.sv
// Power-up and recovery sequencer for the OV7670: XCLK PLL reset and lock debounce,
// camera PWDN/RESET# timing, SCCB configuration handshake and automatic retry.
`timescale 1ns/1ps
module ov7670_power_seq #(
  parameter int unsigned PLL_RST_CYC      = 32,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 2700000,
  parameter int unsigned PWDN_CYC         = 27000,
  parameter int unsigned RST_LOW_CYC      = 27000,
  parameter int unsigned SETTLE_CYC       = 27000,
  parameter int unsigned CFG_TIMEOUT_CYC  = 5400000,
  parameter int unsigned CNT_W            = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       cfg_done,
  output logic       pll_reset,
  output logic       cam_pwdn,
  output logic       cam_reset_n,
  output logic       cfg_start,
  output logic       cam_ready,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_TO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] PWDN_LAST    = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOW_LAST = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CFG_TO_LAST  = CNT_W'(CFG_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_PWDN      = 3'd2,
    S_RST_LOW   = 3'd3,
    S_SETTLE    = 3'd4,
    S_CFG       = 3'd5,
    S_RUN       = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] stable;
  logic             lock_meta;
  logic             lock_s;
  logic             retry;
  logic             entering;

  assign state_dbg = 3'(state);

  // Next state; loss of lock overrides every timer expiry and cfg_done
  always_comb begin
    state_nxt = state;
    retry     = 1'b0;
    case (state)
      S_PLL_RST:   if (timer == PLL_RST_LAST) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s && (stable == STABLE_LAST)) state_nxt = S_PWDN;
        else if (timer == LOCK_TO_LAST)       retry     = 1'b1;
      end
      S_PWDN:      if (timer == PWDN_LAST)    state_nxt = S_RST_LOW;
      S_RST_LOW:   if (timer == RST_LOW_LAST) state_nxt = S_SETTLE;
      S_SETTLE:    if (timer == SETTLE_LAST)  state_nxt = S_CFG;
      S_CFG: begin
        if (cfg_done)                   state_nxt = S_RUN;
        else if (timer == CFG_TO_LAST)  retry     = 1'b1;
      end
      S_RUN:       state_nxt = S_RUN;
      default:     state_nxt = S_PLL_RST;
    endcase
    if (!lock_s && (state inside {S_PWDN, S_RST_LOW, S_SETTLE, S_CFG, S_RUN})) retry = 1'b1;
    if (retry) state_nxt = S_PLL_RST;
    entering = (state_nxt != state);
  end

  // State, timers, lock synchroniser and outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_PLL_RST;
      timer       <= '0;
      stable      <= '0;
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      retry_cnt   <= 4'd0;
      pll_reset   <= 1'b1;
      cam_pwdn    <= 1'b1;
      cam_reset_n <= 1'b0;
      cfg_start   <= 1'b0;
      cam_ready   <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      state     <= state_nxt;

      if (entering)             timer <= '0;
      else if (state != S_RUN)  timer <= timer + CNT_W'(1);

      if (entering || !lock_s)         stable <= '0;
      else if (state == S_WAIT_LOCK)   stable <= stable + CNT_W'(1);

      if (retry && (retry_cnt != 4'hF)) retry_cnt <= retry_cnt + 4'd1;

      pll_reset   <= (state_nxt == S_PLL_RST);
      cam_pwdn    <= (state_nxt inside {S_PLL_RST, S_WAIT_LOCK, S_PWDN});
      cam_reset_n <= (state_nxt inside {S_SETTLE, S_CFG, S_RUN});
      cfg_start   <= (state_nxt == S_CFG) && (state != S_CFG);
      cam_ready   <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_ov7670_power_seq.sv
// Bench for ov7670_power_seq: directed scenarios with literal expectations plus
// randomized lock/config stimulus compared every cycle against a phase-level model.
`timescale 1ns/1ps
module tb_ov7670_power_seq;

  localparam int P_PLL = 4;
  localparam int P_STB = 8;
  localparam int P_LTO = 64;
  localparam int P_PW  = 5;
  localparam int P_RL  = 5;
  localparam int P_ST  = 5;
  localparam int P_CTO = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       cfg_done = 1'b0;
  logic       pll_reset, cam_pwdn, cam_reset_n, cfg_start, cam_ready;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  ov7670_power_seq #(
    .PLL_RST_CYC(P_PLL), .LOCK_STABLE_CYC(P_STB), .LOCK_TIMEOUT_CYC(P_LTO),
    .PWDN_CYC(P_PW), .RST_LOW_CYC(P_RL), .SETTLE_CYC(P_ST),
    .CFG_TIMEOUT_CYC(P_CTO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_done(cfg_done),
    .pll_reset(pll_reset), .cam_pwdn(cam_pwdn), .cam_reset_n(cam_reset_n),
    .cfg_start(cfg_start), .cam_ready(cam_ready), .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number, cycles left in fixed-length phases, lock pipeline as two samples
  int m_ph, m_left, m_stable, m_waited, m_retries;
  bit m_start, m_lk0, m_lk1;

  function automatic int dur(input int p);
    case (p)
      0:       return P_PLL;
      2:       return P_PW;
      3:       return P_RL;
      4:       return P_ST;
      default: return 0;
    endcase
  endfunction

  task automatic m_enter(input int p);
    m_ph     = p;
    m_left   = dur(p);
    m_stable = 0;
    m_waited = 0;
    m_start  = (p == 5);
  endtask

  task automatic m_step();
    bit ls;
    bit rty;
    ls    = m_lk1;
    m_lk1 = m_lk0;
    m_lk0 = pll_lock;
    m_start = 0;
    rty   = 0;
    if (m_ph >= 2 && !ls) rty = 1;
    else case (m_ph)
      0, 2, 3, 4: begin
        m_left--;
        if (m_left == 0) m_enter(m_ph + 1);
      end
      1: begin
        m_stable = ls ? m_stable + 1 : 0;
        m_waited++;
        if (m_stable == P_STB)      m_enter(2);
        else if (m_waited == P_LTO) rty = 1;
      end
      5: begin
        m_waited++;
        if (cfg_done)               m_enter(6);
        else if (m_waited == P_CTO) rty = 1;
      end
      default: ;
    endcase
    if (rty) begin
      if (m_retries < 15) m_retries++;
      m_enter(0);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_enter(0);
      m_start = 0; m_retries = 0; m_lk0 = 0; m_lk1 = 0;
    end else m_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("pll_reset",   int'(pll_reset),   int'(m_ph == 0));
      chk("cam_pwdn",    int'(cam_pwdn),    int'(m_ph <= 2));
      chk("cam_reset_n", int'(cam_reset_n), int'(m_ph >= 4));
      chk("cfg_start",   int'(cfg_start),   int'(m_start));
      chk("cam_ready",   int'(cam_ready),   int'(m_ph == 6));
      chk("retry_cnt",   int'(retry_cnt),   m_retries);
      chk("state_dbg",   int'(state_dbg),   m_ph);
    end
  end

  // SCCB responder: mode 0 answers cfg_start after cfg_delay cycles, 1 never, 2 random noise
  int cfg_mode = 0;
  int cfg_delay = 3;
  int cd = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cd = 0;
      cfg_done = 1'b0;
    end else begin
      if (cd > 0) begin
        cd--;
        cfg_done = (cd == 0);
      end else cfg_done = (cfg_mode == 2) && ($urandom_range(0, 15) == 0);
      if (cfg_start && cfg_mode == 0) begin
        cd = cfg_delay;
        if (cfg_delay == 0) cfg_done = 1'b1;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"},   int'(pll_reset),   1);
    chk({tag, "_cam_pwdn"},    int'(cam_pwdn),    1);
    chk({tag, "_cam_reset_n"}, int'(cam_reset_n), 0);
    chk({tag, "_cfg_start"},   int'(cfg_start),   0);
    chk({tag, "_cam_ready"},   int'(cam_ready),   0);
    chk({tag, "_retry_cnt"},   int'(retry_cnt),   0);
    chk({tag, "_state"},       int'(state_dbg),   0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pll_lock = 1'b0;
    cfg_mode = 0;
    cfg_delay = 3;
    @(negedge clk);
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_state(input int s, input int lim, input string name);
    int n;
    n = 0;
    while (int'(state_dbg) != s && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(state_dbg), s);
  endtask

  task automatic wait_start(input int lim, input string name);
    int n;
    n = 0;
    while (!cfg_start && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(cfg_start), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  int hi_tab [5] = '{1000, 998, 990, 900, 0};

  initial begin
    int t_low, t_pwdn, t_pwdn_lo, t_rsthi, t_start, t_ready, n_start, hi;

    // Nominal sequence, lock from cycle 10, cfg_done 3 cycles after cfg_start
    do_reset();
    t_low = -1; t_pwdn = -1; t_pwdn_lo = -1; t_rsthi = -1; t_start = -1; t_ready = -1; n_start = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 10) pll_lock = 1'b1;
      if (t_low < 0 && !pll_reset) t_low = c;
      if (t_pwdn < 0 && state_dbg == 3'd2) t_pwdn = c;
      if (t_pwdn_lo < 0 && !cam_pwdn) t_pwdn_lo = c;
      if (t_rsthi < 0 && cam_reset_n) t_rsthi = c;
      if (cfg_start) begin
        n_start++;
        if (t_start < 0) t_start = c;
      end
      if (t_ready < 0 && cam_ready) t_ready = c;
    end
    chk("nom_pll_reset_drop", t_low, 4);
    chk("nom_pwdn_entry", t_pwdn, 20);
    chk("nom_pwdn_release", t_pwdn_lo, 25);
    chk("nom_reset_n_rise", t_rsthi, 30);
    chk("nom_cfg_start_time", t_start, 35);
    chk("nom_cfg_start_count", n_start, 1);
    chk("nom_cam_ready_time", t_ready, 39);
    chk("nom_cam_ready_held", int'(cam_ready), 1);
    chk("nom_retry_cnt", int'(retry_cnt), 0);

    // One-cycle lock glitch after 5 stable cycles restarts the debounce
    do_reset();
    pll_lock = 1'b1;
    t_pwdn = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 7) pll_lock = 1'b0;
      if (c == 8) pll_lock = 1'b1;
      if (t_pwdn < 0 && state_dbg == 3'd2) t_pwdn = c;
    end
    chk("glitch_pwdn_entry", t_pwdn, 18);

    // No lock: lock timeout retries, saturating count
    do_reset();
    repeat (68) @(negedge clk);
    chk("nolock_retry1", int'(retry_cnt), 1);
    chk("nolock_state1", int'(state_dbg), 0);
    repeat (68) @(negedge clk);
    chk("nolock_retry2", int'(retry_cnt), 2);
    repeat (68 * 14) @(negedge clk);
    chk("nolock_retry_sat", int'(retry_cnt), 15);

    // Config timeout
    do_reset();
    pll_lock = 1'b1;
    cfg_mode = 1;
    wait_start(200, "cfgto_first_start");
    repeat (31) @(negedge clk);
    chk("cfgto_still_cfg", int'(state_dbg), 5);
    @(negedge clk);
    chk("cfgto_state", int'(state_dbg), 0);
    chk("cfgto_retry", int'(retry_cnt), 1);
    @(negedge clk);
    wait_start(200, "cfgto_second_start");

    // Lock loss while running
    do_reset();
    pll_lock = 1'b1;
    cfg_delay = 2;
    wait_state(6, 200, "run_reached");
    repeat (5) @(negedge clk);
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    chk("loss_ready_latency", int'(cam_ready), 1);
    @(negedge clk);
    chk("loss_cam_ready", int'(cam_ready), 0);
    chk("loss_cam_pwdn", int'(cam_pwdn), 1);
    chk("loss_cam_reset_n", int'(cam_reset_n), 0);
    chk("loss_pll_reset", int'(pll_reset), 1);
    chk("loss_retry", int'(retry_cnt), 1);

    // Async reset pulse in the middle of the RESET# low phase
    pll_lock = 1'b1;
    wait_state(3, 400, "rstlow_reached");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    #1 rst_n = 1'b1;
    wait_state(6, 200, "async_rerun");
    chk("async_retry", int'(retry_cnt), 0);

    // Randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      hi = hi_tab[$urandom_range(0, 4)];
      cfg_mode = $urandom_range(0, 2);
      cfg_delay = $urandom_range(0, 40);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        pll_lock = ($urandom_range(0, 999) < hi);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
